// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder and its shift-beat sequencer.
// The single-cycle datapath also pulls its ALUop and control codes from here.
package alu_ctrl_pkg;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_NAND  = 3'b001;
   localparam logic [2:0] OP_SLT   = 3'b010;
   localparam logic [2:0] OP_SHIFT = 3'b011;
   localparam logic [2:0] OP_ADDI  = 3'b100;
   localparam logic [2:0] OP_BEQ   = 3'b101;
   localparam logic [2:0] OP_MEM   = 3'b111;

   localparam logic [2:0] CTRL_NOP  = 3'b000;
   localparam logic [2:0] CTRL_ADD  = 3'b001;
   localparam logic [2:0] CTRL_NAND = 3'b010;
   localparam logic [2:0] CTRL_SLT  = 3'b011;
   localparam logic [2:0] CTRL_SL   = 3'b100;
   localparam logic [2:0] CTRL_SR   = 3'b101;
   localparam logic [2:0] CTRL_BEQ  = 3'b110;
   localparam logic [2:0] CTRL_MEM  = 3'b111;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   typedef struct packed {
      logic [2:0] code;
      logic       is_shift;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUop/funct decode table, shared with the single-cycle datapath.
// Anything not in the table decodes to a NOP flagged as illegal.
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
#(
   parameter int OP_W    = 3,
   parameter int FUNCT_W = 1
) (
   input  logic [OP_W-1:0]    op,
   input  logic [FUNCT_W-1:0] funct,
   output dec_t               dec
);

   logic upper_nz;

   generate
      if (OP_W > 3) begin : g_upper
         assign upper_nz = |op[OP_W-1:3];
      end else begin : g_no_upper
         assign upper_nz = 1'b0;
      end
   endgenerate

   always_comb begin
      // NOTE: full default first so no path through the case can infer a latch.
      dec = '{code: CTRL_NOP, is_shift: 1'b0, illegal: 1'b1};
      if (!upper_nz) begin
         case (op[2:0])
            OP_ADD:   if (funct[0])  dec = '{code: CTRL_ADD,  is_shift: 1'b0, illegal: 1'b0};
            OP_NAND:  if (funct[0])  dec = '{code: CTRL_NAND, is_shift: 1'b0, illegal: 1'b0};
            OP_SLT:   dec = '{code: CTRL_SLT, is_shift: 1'b0, illegal: 1'b0};
            OP_SHIFT: dec = '{code: funct[0] ? CTRL_SR : CTRL_SL, is_shift: 1'b1, illegal: 1'b0};
            OP_ADDI:  if (!funct[0]) dec = '{code: CTRL_ADD,  is_shift: 1'b0, illegal: 1'b0};
            OP_BEQ:   dec = '{code: CTRL_BEQ, is_shift: 1'b0, illegal: 1'b0};
            OP_MEM:   dec = '{code: CTRL_MEM, is_shift: 1'b0, illegal: 1'b0};
            default:  ;
         endcase
      end
   end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder behind valid/ready; shifts are expanded into
// one single-bit shift beat per accepted output handshake.
module alu_ctrl_seq
   import alu_ctrl_pkg::*;
#(
   parameter int OP_W    = 3,
   parameter int FUNCT_W = 1,
   parameter int SHAMT_W = 3,
   parameter int CTRL_W  = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [OP_W-1:0]    ALUop,
   input  logic [FUNCT_W-1:0] funct,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CTRL_W-1:0]  ALUctrlbits,
   output logic               out_last,
   output logic               illegal,
   output logic               busy
);

   logic [0:0]         state;
   logic [SHAMT_W-1:0] count;
   dec_t               dec;
   logic [2:0]         load_code;
   logic               accept;
   logic               out_fire;
   logic               multi_beat;

   alu_ctrl_decode #(
      .OP_W    (OP_W),
      .FUNCT_W (FUNCT_W)
   ) u_decode (
      .op    (ALUop),
      .funct (funct),
      .dec   (dec)
   );

   assign in_ready   = (state == ST_IDLE) && (!out_valid || out_ready);
   assign accept     = in_valid && in_ready;
   assign out_fire   = out_valid && out_ready;
   assign busy       = (state != ST_IDLE) || out_valid;

   // A zero-length shift still emits one beat, but as a NOP.
   assign load_code  = (dec.is_shift && (shamt == '0)) ? CTRL_NOP : dec.code;
   assign multi_beat = dec.is_shift && (shamt > SHAMT_W'(1));

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      if (reset) begin
         state       <= ST_IDLE;
         count       <= '0;
         out_valid   <= 1'b0;
         ALUctrlbits <= '0;
         out_last    <= 1'b0;
         illegal     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  out_valid   <= 1'b1;
                  ALUctrlbits <= CTRL_W'(load_code);
                  illegal     <= dec.illegal;
                  if (multi_beat) begin
                     out_last <= 1'b0;
                     count    <= shamt - SHAMT_W'(1);
                     state    <= ST_SHIFT;
                  end else begin
                     out_last <= 1'b1;
                  end
               end else if (out_fire) begin
                  out_valid <= 1'b0;
               end
            end
            ST_SHIFT: begin
               // out_valid stays high here; each consumed beat loads the next one.
               if (out_fire) begin
                  count <= count - SHAMT_W'(1);
                  if (count == SHAMT_W'(1)) begin
                     out_last <= 1'b1;
                     state    <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
